gpio_switch_conditioner: RTL and testbench

Debounces and edge-detects the 32 DIP switch values produced by the GPIO board driver (`DIP_SW`), which arrive from a slow, separately clocked sampling process. Sits directly downstream of the GPIO board driver in the `clock_50` domain. Feeds clean levels and one-cycle change pulses to the rest of the design, such as mode selects and single-step controls.

---
 rtl/gpio_switch_conditioner_if.sv | 33 +++
 rtl/gpio_switch_conditioner.sv | 128 ++++++++++++
 tb/tb_gpio_switch_conditioner.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/gpio_switch_conditioner_if.sv
// Switch-word bundle between the GPIO board driver and the switch conditioner.
// GPIO_SW_TOGGLE_EN adds the latched sw_toggle word.
interface gpio_switch_conditioner_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] DIP_SW;
    logic [WIDTH-1:0] sw_state;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;
    logic             sample_tick;
`ifdef GPIO_SW_TOGGLE_EN
    logic [WIDTH-1:0] sw_toggle;

    modport master (
        output DIP_SW,
        input  sw_state, sw_rise, sw_fall, sw_changed, sample_tick, sw_toggle
    );
    modport slave (
        input  DIP_SW,
        output sw_state, sw_rise, sw_fall, sw_changed, sample_tick, sw_toggle
    );
`else
    modport master (
        output DIP_SW,
        input  sw_state, sw_rise, sw_fall, sw_changed, sample_tick
    );
    modport slave (
        input  DIP_SW,
        output sw_state, sw_rise, sw_fall, sw_changed, sample_tick
    );
`endif
endinterface

// File: rtl/gpio_switch_conditioner.sv
// Synchronizes, debounces and edge-detects the DIP switch word in the clock_50 domain.
// Optional feature macro: GPIO_SW_TOGGLE_EN (adds per-bit latched toggle outputs).
module gpio_switch_bit #(
    parameter int STABLE_CNT = 4
) (
    input  logic clock_50,
    input  logic reset,
    input  logic sample_en,
    input  logic sync,
    output logic state,
    output logic rise,
    output logic fall,
`ifdef GPIO_SW_TOGGLE_EN
    output logic toggle,
`endif
    output logic accept
);
    localparam int CW = $clog2(STABLE_CNT) + 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);

    logic [CW-1:0] cnt;

    // Combinational so the top can OR all bits into sw_changed on the same edge.
    assign accept = sample_en && (sync != state) && (cnt == LAST);

    always_ff @(posedge clock_50) begin
        if (reset) begin
            cnt   <= '0;
            state <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= accept && sync;
            fall <= accept && !sync;
            if (sample_en) begin
                if (sync == state) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    state <= sync;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

`ifdef GPIO_SW_TOGGLE_EN
    always_ff @(posedge clock_50) begin
        if (reset)
            toggle <= 1'b0;
        else if (accept && sync)
            toggle <= ~toggle;
    end
`endif
endmodule

module gpio_switch_conditioner #(
    parameter int WIDTH      = 32,
    parameter int SAMPLE_DIV = 131072,
    parameter int STABLE_CNT = 4
) (
    input  logic                        clock_50,
    input  logic                        reset,
    gpio_switch_conditioner_if.slave    bus
);
    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] accept;
    logic [DW-1:0]    div;
    logic             sample_en;
    logic             changed;
    logic             tick;

    assign sample_en = (div == DIV_LAST);

    // Two-flop synchronizer per bit; bits may land on different cycles.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            meta    <= '0;
            sync    <= '0;
            div     <= '0;
            tick    <= 1'b0;
            changed <= 1'b0;
        end else begin
            meta    <= bus.DIP_SW;
            sync    <= meta;
            div     <= sample_en ? '0 : div + DW'(1);
            tick    <= sample_en;
            changed <= |accept;
        end
    end

`ifdef GPIO_SW_TOGGLE_EN
    logic [WIDTH-1:0] toggle;
    assign bus.sw_toggle = toggle;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_switch_bit #(
            .STABLE_CNT (STABLE_CNT)
        ) u_bit (
            .clock_50  (clock_50),
            .reset     (reset),
            .sample_en (sample_en),
            .sync      (sync[i]),
            .state     (state[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
`ifdef GPIO_SW_TOGGLE_EN
            .toggle    (toggle[i]),
`endif
            .accept    (accept[i])
        );
    end

    assign bus.sw_state    = state;
    assign bus.sw_rise     = rise;
    assign bus.sw_fall     = fall;
    assign bus.sw_changed  = changed;
    assign bus.sample_tick = tick;
endmodule

// File: tb/tb_gpio_switch_conditioner.sv
// Scoreboard bench for gpio_switch_conditioner: expected changes are queued at stimulus
// time and matched against each pulse the DUT emits, including the sample index it lands on.
module tb_gpio_switch_conditioner;
    localparam int WIDTH      = 32;
    localparam int SAMPLE_DIV = 8;
    localparam int STABLE_CNT = 3;

    logic clock_50 = 1'b0;
    logic reset    = 1'b1;
    always #5 clock_50 = ~clock_50;

    gpio_switch_conditioner_if #(.WIDTH(WIDTH)) bus ();

    gpio_switch_conditioner #(
        .WIDTH      (WIDTH),
        .SAMPLE_DIV (SAMPLE_DIV),
        .STABLE_CNT (STABLE_CNT)
    ) dut (
        .clock_50 (clock_50),
        .reset    (reset),
        .bus      (bus)
    );

    typedef struct {
        logic [31:0] rise;
        logic [31:0] fall;
        logic [31:0] state;
        logic [31:0] tog;
        int          tick;
    } exp_t;

    exp_t        sb[$];
    int          total    = 0;
    int          bad      = 0;
    int          tick_cnt = 0;
    logic [31:0] exp_state = '0;
    logic [31:0] exp_tog   = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Monitor samples 1 time unit after each active edge.
    always @(posedge clock_50) begin
        exp_t e;
        #1;
        if (reset) begin
            tick_cnt = 0;
        end else begin
            if (bus.sample_tick) tick_cnt++;
            if (bus.sw_changed || (|bus.sw_rise) || (|bus.sw_fall)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {bus.sw_rise, bus.sw_fall}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rise",    bus.sw_rise,    e.rise);
                    chk("fall",    bus.sw_fall,    e.fall);
                    chk("state",   bus.sw_state,   e.state);
                    chk("changed", bus.sw_changed, 1);
                    chk("on_tick", bus.sample_tick, 1);
                    chk("tick_idx", tick_cnt,      e.tick);
`ifdef GPIO_SW_TOGGLE_EN
                    chk("toggle",  bus.sw_toggle,  e.tog);
`endif
                end
            end
        end
    end

    task automatic expect_change(input logic [31:0] nxt, input int ticks);
        exp_t e;
        e.rise  = nxt & ~exp_state;
        e.fall  = exp_state & ~nxt;
        e.state = nxt;
        exp_tog = exp_tog ^ e.rise;
        e.tog   = exp_tog;
        e.tick  = tick_cnt + ticks;
        exp_state = nxt;
        sb.push_back(e);
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clock_50);
            n++;
        end while (!bus.sample_tick && n < 40);
        if (!bus.sample_tick) chk("tick_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock_50);
            n++;
        end
        if (sb.size() != 0) chk("idle_timeout", sb.size(), 0);
    endtask

    // Drive a new word just after a sample; STABLE_CNT samples later it must be accepted.
    task automatic apply(input logic [31:0] v);
        wait_idle();
        wait_tick();
        bus.DIP_SW = v;
        expect_change(v, STABLE_CNT);
    endtask

    initial begin
        logic [31:0] w;
        bus.DIP_SW = 32'hFFFF_FFFF;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_50);
            chk("rst_state", bus.sw_state, 0);
            chk("rst_pulse", {bus.sw_rise | bus.sw_fall, bus.sw_changed, bus.sample_tick}, 0);
`ifdef GPIO_SW_TOGGLE_EN
            chk("rst_toggle", bus.sw_toggle, 0);
`endif
        end
        reset = 1'b0;
        expect_change(32'hFFFF_FFFF, STABLE_CNT);

        apply(32'h8000_0000);
        apply(32'h0000_0000);

        // Bit 5 bounces 1,0,1 over three samples, then holds.
        wait_idle();
        wait_tick();
        bus.DIP_SW = 32'h0000_0020;
        wait_tick();
        bus.DIP_SW = 32'h0000_0000;
        wait_tick();
        bus.DIP_SW = 32'h0000_0020;
        expect_change(32'h0000_0020, STABLE_CNT);

        apply(32'h0000_0022);
        apply(32'h0000_0021);

        // Two differing samples on bit 3, then a one-cycle reset.
        wait_idle();
        wait_tick();
        w = exp_state | 32'h8;
        bus.DIP_SW = w;
        wait_tick();
        wait_tick();
        @(negedge clock_50);
        reset = 1'b1;
        @(negedge clock_50);
        chk("midrst_state", bus.sw_state, 0);
        chk("midrst_pulse", {bus.sw_rise | bus.sw_fall, bus.sw_changed}, 0);
        reset = 1'b0;
        exp_state = '0;
        exp_tog   = '0;
        expect_change(w, STABLE_CNT);

        apply(exp_state | 32'h80);
        apply(exp_state & ~32'h80);
        apply(exp_state | 32'h80);
        apply(exp_state & ~32'h80);

        wait_idle();
        repeat (4) wait_tick();
        chk("final_state", bus.sw_state, exp_state);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
